lsu_dbus: RTL and testbench

Multi-cycle load/store unit sitting directly downstream of the control unit in the core datapath. During the execute stage it takes the ALU-computed address, store data, funct3 and the control unit's `dbus_re`/`dbus_we` strobes. It performs one or two word-wide handshaked transactions on the external data bus and holds `stall` to freeze the control unit until the access completes. It returns a sign- or zero-extended load result for write-back and supports misaligned accesses by splitting them into two bus beats.

---
 rtl/lsu_dbus.sv | 228 ++++++++++++++++++++++
 tb/tb_lsu_dbus.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_dbus.sv
// Load/store unit: turns one execute-stage access into one or two handshaked
// word beats on the data bus, with byte-lane steering and load extension.
module lsu_dbus #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        re,
    input  logic        we,
    input  logic [2:0]  f3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BEAT0 = 3'd1,
        BEAT1 = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [WORD_W-1:0]   addr_q;
    logic [WORD_W-1:0]   addr_n;
    logic [WORD_W-1:0]   wdata_q;
    logic [WORD_W-1:0]   wdata_n;
    logic [2:0]          f3_q;
    logic [2:0]          f3_n;
    logic                re_q;
    logic                re_n;
    logic                we_q;
    logic                we_n;
    logic [WORD_W-1:0]   buf0;
    logic [WORD_W-1:0]   buf0_n;
    logic [WORD_W-1:0]   buf1;
    logic [WORD_W-1:0]   buf1_n;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_n;
    logic                split_q;
    logic                beat_n;
    logic [7:0]          mask_n;
    logic [2*WORD_W-1:0] wide_n;

    // A request with neither or both strobes is treated like an illegal f3.
    function automatic logic access_legal(input logic ld, input logic st, input logic [2:0] fn);
        logic ok;
        ok = 1'b0;
        if (ld && !st) begin
            ok = (fn != 3'b011) && (fn[2:1] != 2'b11);
        end else if (st && !ld) begin
            ok = (fn[2] == 1'b0) && (fn[1:0] != 2'b11);
        end
        return ok;
    endfunction

    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        logic [2:0] n;
        case (sz)
            2'b00:   n = 3'd1;
            2'b01:   n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    function automatic logic [7:0] lane_base(input logic [1:0] sz);
        logic [7:0] m;
        case (sz)
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            default: m = 8'h0F;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] load_ext(input logic [63:0] pair, input logic [1:0] off,
                                             input logic [2:0] fn);
        logic [31:0] v;
        logic [31:0] r;
        v = 32'(pair >> {off, 3'b000});
        case (fn[1:0])
            2'b00:   r = fn[2] ? {24'd0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
            2'b01:   r = fn[2] ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            default: r = v;
        endcase
        return r;
    endfunction

    assign split_q = ({1'b0, addr_q[1:0]} + size_bytes(f3_q[1:0])) > 3'd4;
    assign beat_n  = (state_n == BEAT0) || (state_n == BEAT1);
    assign mask_n  = lane_base(f3_n[1:0]) << addr_n[1:0];
    assign wide_n  = {32'd0, wdata_n} << {addr_n[1:0], 3'b000};
    assign stall   = ((state == IDLE) && start) || (state == BEAT0) ||
                     (state == BEAT1) || (state == FAULT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, access latch, beat capture and per-beat timeout.
    always_comb begin
        state_n = state;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        f3_n    = f3_q;
        re_n    = re_q;
        we_n    = we_q;
        buf0_n  = buf0;
        buf1_n  = buf1;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    if (!access_legal(re, we, f3)) begin
                        state_n = FAULT;
                    end else begin
                        addr_n  = addr;
                        wdata_n = wdata;
                        f3_n    = f3;
                        re_n    = re;
                        we_n    = we;
                        cnt_n   = '0;
                        state_n = BEAT0;
                    end
                end
            end
            BEAT0: begin
                if (mem_ack) begin
                    buf0_n  = mem_rdata;
                    cnt_n   = '0;
                    state_n = split_q ? BEAT1 : DONE;
                end else if (cnt == CNT_LAST) begin
                    state_n = FAULT;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            BEAT1: begin
                if (mem_ack) begin
                    buf1_n  = mem_rdata;
                    state_n = DONE;
                end else if (cnt == CNT_LAST) begin
                    state_n = FAULT;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DONE:    state_n = IDLE;
            FAULT:   state_n = FAULT;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            buf0    <= '0;
            buf1    <= '0;
            cnt     <= '0;
        end else begin
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            f3_q    <= f3_n;
            re_q    <= re_n;
            we_q    <= we_n;
            buf0    <= buf0_n;
            buf1    <= buf1_n;
            cnt     <= cnt_n;
        end
    end

    // Bus fields are loaded on beat entry and held for the whole beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            fault     <= 1'b0;
            rdata     <= '0;
        end else begin
            mem_req <= beat_n;
            mem_we  <= beat_n && we_n;
            if ((state == IDLE) && (state_n == BEAT0)) begin
                mem_addr  <= {addr_n[31:2], 2'b00};
                mem_be    <= mask_n[3:0];
                mem_wdata <= wide_n[31:0];
            end else if ((state == BEAT0) && (state_n == BEAT1)) begin
                mem_addr  <= {addr_q[31:2] + 30'd1, 2'b00};
                mem_be    <= mask_n[7:4];
                mem_wdata <= wide_n[63:32];
            end
            done  <= (state_n == DONE);
            fault <= (state_n == FAULT);
            if ((state_n == DONE) && re_q) begin
                rdata <= load_ext({buf1_n, buf0_n}, addr_q[1:0], f3_q);
            end
        end
    end

endmodule

// File: tb/tb_lsu_dbus.sv
// Scoreboarded bench for lsu_dbus: a bus responder checks each expected beat,
// a completion monitor checks load results and latency on every done pulse.
`timescale 1ns/1ps
module tb_lsu_dbus;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        re = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  f3 = 3'b000;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        stall;
    logic        done;
    logic        fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
    } beat_t;

    typedef struct {
        logic [31:0] rdata;
        int          lat;
        int          start_cyc;
        string       name;
    } done_t;

    beat_t beat_q[$];
    done_t done_q[$];

    lsu_dbus #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .re(re), .we(we), .f3(f3),
        .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .done(done),
        .fault(fault), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input bit ok, input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_beat(input logic [31:0] a, input logic [3:0] be, input logic w,
                             input logic [31:0] wd, input logic [31:0] rd, input int dly);
        beat_t b;
        b.addr = a; b.be = be; b.we = w; b.wdata = wd; b.rdata = rd; b.delay = dly;
        beat_q.push_back(b);
    endtask

    // Bus responder: acks the head beat after its delay and checks its fields.
    int          wait_cnt = 0;
    beat_t       rb;
    logic [31:0] wmask;
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (!rst || !mem_req || beat_q.size() == 0) begin
            wait_cnt = 0;
        end else if (wait_cnt < beat_q[0].delay) begin
            wait_cnt++;
        end else begin
            rb = beat_q.pop_front();
            check(mem_addr == rb.addr, "beat_addr", mem_addr, rb.addr);
            check(mem_be == rb.be, "beat_be", 32'(mem_be), 32'(rb.be));
            check(mem_we == rb.we, "beat_we", 32'(mem_we), 32'(rb.we));
            if (rb.we) begin
                wmask = {{8{rb.be[3]}}, {8{rb.be[2]}}, {8{rb.be[1]}}, {8{rb.be[0]}}};
                check((mem_wdata & wmask) == (rb.wdata & wmask), "beat_wdata",
                      mem_wdata, rb.wdata);
            end
            mem_rdata = rb.rdata;
            mem_ack   = 1'b1;
            wait_cnt  = 0;
        end
    end

    // Completion monitor.
    done_t md;
    always @(negedge clk) begin
        if (rst && done) begin
            check(done_q.size() != 0, "done_expected", 32'(done_q.size()), 32'd1);
            if (done_q.size() != 0) begin
                md = done_q.pop_front();
                check(rdata == md.rdata, {"rdata ", md.name}, rdata, md.rdata);
                check((cyc - md.start_cyc) == md.lat, {"latency ", md.name},
                      32'(cyc - md.start_cyc), 32'(md.lat));
            end
        end
    end

    task automatic access(input logic r, input logic w, input logic [2:0] fn,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input int lat, input string name);
        done_t d;
        int    bad;
        int    n;
        re = r; we = w; f3 = fn; addr = a; wdata = wd; start = 1'b1;
        d.rdata = exp_rd; d.lat = lat; d.start_cyc = cyc; d.name = name;
        done_q.push_back(d);
        bad = 0;
        n = 0;
        #1;
        if (!stall) bad++;
        @(negedge clk);
        while (!done && n < 60) begin
            if (!stall) bad++;
            n++;
            @(negedge clk);
        end
        check(done == 1'b1, {"done_seen ", name}, 32'(done), 32'd1);
        if (stall) bad++;
        check(bad == 0, {"stall ", name}, 32'(bad), 32'd0);
        start = 1'b0; re = 1'b0; we = 1'b0;
        @(negedge clk);
        check({done, stall} == 2'b00, {"idle_after ", name}, 32'({done, stall}), 32'd0);
    endtask

    task automatic reset_check(input string name);
        start = 1'b0; re = 1'b0; we = 1'b0;
        rst = 1'b0;
        #1;
        check(rdata == 32'd0, {"rst_rdata ", name}, rdata, 32'd0);
        check({done, fault, mem_req, mem_we, mem_be, stall} == 9'd0, {"rst_ctrl ", name},
              32'({done, fault, mem_req, mem_we, mem_be, stall}), 32'd0);
        check((mem_addr | mem_wdata) == 32'd0, {"rst_bus ", name},
              mem_addr | mem_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic illegal(input logic r, input logic w, input logic [2:0] fn, input string name);
        int req_seen;
        req_seen = 0;
        re = r; we = w; f3 = fn; addr = 32'h0000_0A00; wdata = 32'h1234_5678; start = 1'b1;
        #1;
        check(stall == 1'b1, {"ill_stall0 ", name}, 32'(stall), 32'd1);
        if (mem_req) req_seen++;
        @(negedge clk);
        check({fault, stall} == 2'b11, {"ill_fault ", name}, 32'({fault, stall}), 32'd3);
        repeat (3) begin
            if (mem_req) req_seen++;
            @(negedge clk);
        end
        check(req_seen == 0, {"ill_noreq ", name}, 32'(req_seen), 32'd0);
        reset_check(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check(rdata == 32'd0, "init_rdata", rdata, 32'd0);
        check({done, fault, mem_req, mem_we, mem_be, stall} == 9'd0, "init_ctrl",
              32'({done, fault, mem_req, mem_we, mem_be, stall}), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        push_beat(32'h0000_0100, 4'b1111, 1'b0, 32'h0, 32'hDEAD_BEEF, 0);
        access(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 2, "lw_aligned");

        push_beat(32'h0000_0200, 4'b1000, 1'b0, 32'h0, 32'h80FF_FFFF, 0);
        access(1'b1, 1'b0, 3'b000, 32'h0000_0203, 32'h0, 32'hFFFF_FF80, 2, "lb_neg");

        push_beat(32'h0000_0200, 4'b1000, 1'b0, 32'h0, 32'h80FF_FFFF, 0);
        access(1'b1, 1'b0, 3'b100, 32'h0000_0203, 32'h0, 32'h0000_0080, 2, "lbu");

        push_beat(32'h0000_0300, 4'b1000, 1'b1, 32'hCD00_0000, 32'h0, 0);
        push_beat(32'h0000_0304, 4'b0001, 1'b1, 32'h0000_00AB, 32'h0, 0);
        access(1'b0, 1'b1, 3'b001, 32'h0000_0303, 32'h0000_ABCD, 32'h0000_0080, 3, "sh_split");

        push_beat(32'h0000_0400, 4'b1100, 1'b0, 32'h0, 32'h3344_5566, 3);
        push_beat(32'h0000_0404, 4'b0011, 1'b0, 32'h0, 32'h7788_1122, 3);
        access(1'b1, 1'b0, 3'b010, 32'h0000_0402, 32'h0, 32'h1122_3344, 9, "lw_split_slow");

        push_beat(32'h0000_0500, 4'b1100, 1'b0, 32'h0, 32'h8001_1234, 1);
        access(1'b1, 1'b0, 3'b001, 32'h0000_0502, 32'h0, 32'hFFFF_8001, 3, "lh_off2");

        push_beat(32'h0000_0500, 4'b1000, 1'b0, 32'h0, 32'hFE00_0000, 0);
        push_beat(32'h0000_0504, 4'b0001, 1'b0, 32'h0, 32'h0000_00C3, 2);
        access(1'b1, 1'b0, 3'b101, 32'h0000_0503, 32'h0, 32'h0000_C3FE, 5, "lhu_split");

        push_beat(32'h0000_0600, 4'b1110, 1'b1, 32'h2233_4400, 32'h0, 0);
        push_beat(32'h0000_0604, 4'b0001, 1'b1, 32'h0000_0011, 32'h0, 0);
        access(1'b0, 1'b1, 3'b010, 32'h0000_0601, 32'h1122_3344, 32'h0000_C3FE, 3, "sw_split");

        push_beat(32'h0000_0700, 4'b0100, 1'b1, 32'h00A5_0000, 32'h0, 0);
        access(1'b0, 1'b1, 3'b000, 32'h0000_0702, 32'h0000_00A5, 32'h0000_C3FE, 2, "sb");

        push_beat(32'hFFFF_FFFC, 4'b1100, 1'b0, 32'h0, 32'hBBAA_0000, 0);
        push_beat(32'h0000_0000, 4'b0011, 1'b0, 32'h0, 32'h0000_DDCC, 0);
        access(1'b1, 1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, 32'hDDCC_BBAA, 3, "lw_wrap");

        // No responder beat queued: the access must time out after 4 beat cycles.
        re = 1'b1; we = 1'b0; f3 = 3'b010; addr = 32'h0000_0900; start = 1'b1;
        @(negedge clk);
        bad = 0;
        repeat (4) begin
            if (!mem_req || fault || !stall) bad++;
            @(negedge clk);
        end
        check(bad == 0, "timeout_wait", 32'(bad), 32'd0);
        check({mem_req, fault, stall} == 3'b011, "timeout_fault",
              32'({mem_req, fault, stall}), 32'd3);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check({mem_req, fault, stall} == 3'b011, "fault_sticky",
              32'({mem_req, fault, stall}), 32'd3);
        reset_check("after_timeout");

        illegal(1'b1, 1'b0, 3'b011, "ld_f3_011");
        illegal(1'b1, 1'b1, 3'b010, "re_and_we");
        illegal(1'b0, 1'b1, 3'b100, "st_f3_100");

        // Reset in the middle of a beat drops mem_req without a clock edge.
        re = 1'b1; we = 1'b0; f3 = 3'b010; addr = 32'h0000_0A04; start = 1'b1;
        repeat (2) @(negedge clk);
        check(mem_req == 1'b1, "midbeat_req", 32'(mem_req), 32'd1);
        start = 1'b0; re = 1'b0;
        #2 rst = 1'b0;
        #1;
        check(mem_req == 1'b0, "midbeat_async_drop", 32'(mem_req), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        push_beat(32'h0000_0000, 4'b0001, 1'b1, 32'h0000_0012, 32'h0, 0);
        access(1'b0, 1'b1, 3'b000, 32'h0000_0000, 32'h0000_0012, 32'h0, 2, "sb_after_reset");

        check(beat_q.size() == 0, "beats_drained", 32'(beat_q.size()), 32'd0);
        check(done_q.size() == 0, "dones_drained", 32'(done_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
